// File: rtl/adc_sreg_pkg.sv
// ---------------------------------------------------------------------------
// adc_sreg_pkg : frame layout, rw encoding and FSM states for the ADC serial port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adc_sreg_pkg;
  localparam int ADC_ADDR_W     = 3;
  localparam int ADC_DATA_W     = 9;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_HDR_BITS   = 7;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } adc_state_e;
endpackage

`default_nettype wire

// File: rtl/adc_sreg_responder_sync.sv
// ---------------------------------------------------------------------------
// sig_sync_edge : N-stage synchronizer with registered rise/fall pulses
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sig_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Flops come out of reset at the idle-high bus level so no edge fires on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
      rise   <= r_sync[STAGES-1] & ~r_prev;
      fall   <= ~r_sync[STAGES-1] & r_prev;
    end
  end
endmodule

`default_nettype wire

// File: rtl/adc_sreg_responder.sv
// ---------------------------------------------------------------------------
// adc_sreg_responder : oversampled 3-wire ADC register model (8 x 9-bit)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adc_sreg_responder
  import adc_sreg_pkg::*;
#(
  parameter int                         NUM_REGS    = 8,
  parameter int                         DATA_W      = ADC_DATA_W,
  parameter int                         SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] REG_RESET   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         sload,
  input  logic                         sdata_i,
  output logic                         sdata_o,
  output logic                         sdata_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic                         wr_stb,
  output logic [ADC_ADDR_W-1:0]        wr_addr,
  output logic                         frame_err
);
  localparam logic [4:0] c_ADDR_LAST  = 5'd3;
  localparam logic [4:0] c_HDR_LAST   = 5'(ADC_HDR_BITS - 1);
  localparam logic [4:0] c_FRAME_LAST = 5'(ADC_FRAME_BITS - 1);

  logic w_sclk_rise, w_sclk_fall, w_sload_rise, w_sload_fall;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic w_sdata;

  adc_state_e r_state, w_state_nxt;
  logic [4:0]            r_bitcnt;
  logic [DATA_W-1:0]     r_shreg, r_rd_shift;
  logic                  r_rw, r_overrun;
  logic [ADC_ADDR_W-1:0] r_addr;
  logic [NUM_REGS*DATA_W-1:0] r_regs;
  logic w_start, w_shift, w_drive, w_ovr, w_commit, w_abort;

  sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d(sclk), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sload_sync (
    .clk(clk), .rst_n(rst_n), .d(sload), .rise(w_sload_rise), .fall(w_sload_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sdata_sync <= '1;
    else        r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], sdata_i};
  end
  assign w_sdata = r_sdata_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // sload_rise is tested first everywhere so a coincident sclk edge is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_drive     = 1'b0;
    w_ovr       = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sload_fall) begin
          w_start     = 1'b1;
          w_state_nxt = HDR;
        end
      end
      HDR: begin
        if (w_sload_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
          if (r_bitcnt == c_HDR_LAST) w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_sload_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
          if (r_bitcnt == c_FRAME_LAST) w_state_nxt = DONE;
        end else if (w_sclk_fall && r_rw == RW_READ) begin
          w_drive = 1'b1;
        end
      end
      DONE: begin
        if (w_sload_rise) begin
          w_state_nxt = IDLE;
          if (r_overrun)              w_abort  = 1'b1;
          else if (r_rw == RW_WRITE)  w_commit = 1'b1;
        end else if (w_sclk_rise) begin
          w_ovr = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt   <= '0;
      r_shreg    <= '0;
      r_rd_shift <= '0;
      r_rw       <= RW_READ;
      r_addr     <= '0;
      r_overrun  <= 1'b0;
      r_regs     <= REG_RESET;
      sdata_o    <= 1'b0;
      sdata_oe   <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      frame_err  <= 1'b0;
    end else begin
      wr_stb    <= w_commit;
      frame_err <= w_abort;
      if (w_start) begin
        r_bitcnt  <= '0;
        r_shreg   <= '0;
        r_overrun <= 1'b0;
      end
      if (w_shift) begin
        r_bitcnt <= r_bitcnt + 5'd1;
        r_shreg  <= {r_shreg[DATA_W-2:0], w_sdata};
        // Header bits 0..3 are rw and addr; they sit in r_shreg[2:0] plus the live bit.
        if (r_bitcnt == c_ADDR_LAST) {r_rw, r_addr} <= {r_shreg[2:0], w_sdata};
        if (r_bitcnt == c_HDR_LAST) begin
          r_shreg    <= '0;
          r_rd_shift <= r_regs[r_addr*DATA_W +: DATA_W];
        end
      end
      if (w_ovr) r_overrun <= 1'b1;
      if (w_drive) begin
        sdata_oe   <= 1'b1;
        sdata_o    <= r_rd_shift[DATA_W-1];
        r_rd_shift <= {r_rd_shift[DATA_W-2:0], 1'b0};
      end
      if (w_sload_rise) begin
        sdata_oe <= 1'b0;
        sdata_o  <= 1'b0;
      end
      if (w_commit) begin
        r_regs[r_addr*DATA_W +: DATA_W] <= r_shreg;
        wr_addr <= r_addr;
      end
    end
  end

  assign regs = r_regs;
endmodule

`default_nettype wire

// File: tb/tb_adc_sreg_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_sreg_responder : directed frame-level bench for adc_sreg_responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_adc_sreg_responder;
  localparam logic [71:0] RST_IMG = 72'h12_3456_789A_BCDE_F011;
  localparam int HALF = 100;

  logic        clk = 1'b0;
  logic        rst_n, sclk, sload, sdata_i;
  logic        sdata_o, sdata_oe, wr_stb, frame_err;
  logic [71:0] regs;
  logic [2:0]  wr_addr;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int err_cnt = 0;

  adc_sreg_responder #(
    .NUM_REGS(8), .DATA_W(9), .SYNC_STAGES(2), .REG_RESET(RST_IMG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sload(sload), .sdata_i(sdata_i),
    .sdata_o(sdata_o), .sdata_oe(sdata_oe), .regs(regs),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb)    stb_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Host side: bits launched after sclk falls, read bits sampled just before sclk rises.
  task automatic frame(input logic rw, input logic [2:0] a, input logic [8:0] d,
                       input int nbits, input int rst_at, output logic [8:0] rd);
    logic [15:0] bits;
    bits = {rw, a, 3'b000, d};
    rd   = '0;
    sload = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      sclk    = 1'b0;
      sdata_i = (i < 16) ? bits[15-i] : 1'b0;
      #HALF;
      if (i >= 7 && i < 16) rd = {rd[7:0], sdata_o};
      if (rw == 1'b0 && i == 6)  chk("oe_low_in_header", 72'(sdata_oe), 72'd0);
      if (rw == 1'b0 && i == 15) chk("oe_high_in_data", 72'(sdata_oe), 72'd1);
      if (i == rst_at) begin
        chk("oe_before_reset", 72'(sdata_oe), 72'd1);
        rst_n = 1'b0;
        #1;
        chk("oe_async_reset", 72'(sdata_oe), 72'd0);
        chk("regs_async_reset", regs, RST_IMG);
        break;
      end
      sclk = 1'b1;
      #HALF;
    end
    sclk  = 1'b1;
    sload = 1'b1;
    #(2*HALF);
  endtask

  initial begin
    logic [71:0] exp;
    logic [8:0]  rd;
    int s0, e0;

    rst_n = 1'b0; sclk = 1'b1; sload = 1'b1; sdata_i = 1'b1;
    #40;
    chk("rst_regs", regs, RST_IMG);
    chk("rst_sdata_oe", 72'(sdata_oe), 72'd0);
    chk("rst_sdata_o", 72'(sdata_o), 72'd0);
    chk("rst_wr_stb", 72'(wr_stb), 72'd0);
    chk("rst_wr_addr", 72'(wr_addr), 72'd0);
    chk("rst_frame_err", 72'(frame_err), 72'd0);
    #20 rst_n = 1'b1;
    #40;
    exp = RST_IMG;

    // write addr 5 = 0x1A5
    s0 = stb_cnt; e0 = err_cnt;
    frame(1'b1, 3'd5, 9'h1A5, 16, -1, rd);
    exp[45 +: 9] = 9'h1A5;
    chk("wr5_stb_count", 72'(stb_cnt - s0), 72'd1);
    chk("wr5_no_err", 72'(err_cnt - e0), 72'd0);
    chk("wr5_wr_addr", 72'(wr_addr), 72'd5);
    chk("wr5_regs", regs, exp);

    // read back addr 5
    s0 = stb_cnt;
    frame(1'b0, 3'd5, 9'h000, 16, -1, rd);
    chk("rd5_data", 72'(rd), 72'h1A5);
    chk("rd5_oe_after", 72'(sdata_oe), 72'd0);
    chk("rd5_no_stb", 72'(stb_cnt - s0), 72'd0);

    // aborted write after 10 bits
    s0 = stb_cnt; e0 = err_cnt;
    frame(1'b1, 3'd2, 9'h0AA, 10, -1, rd);
    chk("abort_err_count", 72'(err_cnt - e0), 72'd1);
    chk("abort_no_stb", 72'(stb_cnt - s0), 72'd0);
    chk("abort_regs", regs, exp);

    // overrun: 17 rises
    s0 = stb_cnt; e0 = err_cnt;
    frame(1'b1, 3'd0, 9'h155, 17, -1, rd);
    chk("ovr_err_count", 72'(err_cnt - e0), 72'd1);
    chk("ovr_no_stb", 72'(stb_cnt - s0), 72'd0);
    chk("ovr_regs", regs, exp);

    // reset in the middle of a read
    frame(1'b0, 3'd5, 9'h000, 16, 11, rd);
    #99 rst_n = 1'b1;
    #100;
    exp = RST_IMG;
    chk("post_rst_oe", 72'(sdata_oe), 72'd0);
    chk("post_rst_regs", regs, exp);

    s0 = stb_cnt;
    frame(1'b1, 3'd7, 9'h0FF, 16, -1, rd);
    exp[63 +: 9] = 9'h0FF;
    chk("wr7_stb_count", 72'(stb_cnt - s0), 72'd1);
    chk("wr7_wr_addr", 72'(wr_addr), 72'd7);
    chk("wr7_regs", regs, exp);

    // back-to-back write then read of addr 1
    s0 = stb_cnt;
    frame(1'b1, 3'd1, 9'h003, 16, -1, rd);
    frame(1'b0, 3'd1, 9'h000, 16, -1, rd);
    exp[9 +: 9] = 9'h003;
    chk("b2b_rd_data", 72'(rd), 72'h003);
    chk("b2b_stb_count", 72'(stb_cnt - s0), 72'd1);
    chk("b2b_regs", regs, exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/adc_sreg_responder.md
Name: adc_sreg_responder

Overview:
- Serial-port responder for the CCD ADC 3-wire configuration interface: sload, sclk, sdata.
- Decodes the 16-bit frames a host issues: rw, 3-bit address, 3 don't-care bits, 9 data bits MSB-first.
- Holds an 8 x 9-bit register file, updated by writes and returned on reads.
- Used as an on-FPGA ADC register model, both for loopback bring-up and as a shadow of the external ADC configuration; all logic runs on the system clk, with the serial pins oversampled.

Parameters:
- NUM_REGS, 8, number of 9-bit registers; address width is fixed at 3.
- DATA_W, 9, register width.
- SYNC_STAGES, 2, synchronizer depth on sclk, sload and sdata_i; legal range 2..3.
- REG_RESET, 72'h0, flat reset image; reg n is bits [9n+8:9n].

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  serial clock from host, asynchronous to clk.
- sload  in  1  frame select, active low.
- sdata_i  in  1  serial data from host.
- sdata_o  out  1  serial read data.
- sdata_oe  out  1  high while the responder drives sdata; pad tristate lives at top level.
- regs  out  72  flat register file contents.
- wr_stb  out  1  one-clk pulse when a write commits.
- wr_addr  out  3  address of the last committed write.
- frame_err  out  1  one-clk pulse when a frame is aborted.

Behaviour:
- Reset (rst_n low, async):
  - regs = REG_RESET.
  - sdata_o = 0, sdata_oe = 0, wr_stb = 0, wr_addr = 0, frame_err = 0.
  - Bit counter = 0, FSM = IDLE, synchronizer flops = 1 (idle bus levels).
- Inputs pass through SYNC_STAGES flops.
  - sclk_rise and sclk_fall are detected on the synchronized sclk.
  - sload_fall and sload_rise are detected on the synchronized sload.
- Host timing: the host launches each bit on sclk falling edges. The responder samples sdata on each sclk_rise while sload is low.
- FSM IDLE:
  - sload_fall -> HDR; clear bit counter bitcnt (5 bits) and the shift register.
  - sclk edges are ignored.
- HDR, bits 0..6, one per sclk_rise:
  - bit0 = rw (1 = write, 0 = read).
  - bits 1..3 = addr[2:0], MSB first.
  - bits 4..6 are discarded.
  - bitcnt increments on each rise; at bitcnt = 7 -> DATA.
  - If rw = 0: on the sclk_fall following the 7th rise, set sdata_oe = 1 and sdata_o = reg[addr][8].
- DATA, bits 7..15:
  - Write: shift sdata_i into the 9-bit shift register on each rise.
  - Read: on each subsequent sclk_fall, advance sdata_o to the next lower bit (reg[addr][7] .. [0]). The value is snapshotted when the header completes, so it is stable during the frame.
  - At bitcnt = 16 -> DONE.
- DONE:
  - Further sclk_rise beyond 16 sets an overrun flag.
  - On sload_rise: if rw = 1 and there was no overrun, commit the shift register to reg[addr], pulse wr_stb, and set wr_addr = addr. Then IDLE.
  - If there was an overrun, pulse frame_err with no commit.
- Abort: sload_rise in HDR or DATA (fewer than 16 bits) -> frame_err pulse, no register change, IDLE.
- sdata_oe drops to 0 within 1 clk of the synchronized sload_rise in any state; sdata_o returns to 0.
- Simultaneous events in the same clk:
  - sload_rise wins over sclk_rise; that sclk edge is not counted.
  - sload_fall while already active is impossible by construction.
- wr_stb and frame_err are mutually exclusive and each lasts exactly 1 clk.
- Latency: a commit is visible on regs SYNC_STAGES+2 clk after the raw sload rise.
- Reset mid-frame: immediate return to IDLE, no commit, sdata_oe = 0.

Decomposition:
- Shared package adc_sreg_pkg holds:
  - ADC_ADDR_W = 3, ADC_DATA_W = 9, ADC_FRAME_BITS = 16, ADC_HDR_BITS = 7.
  - The rw encoding constants: RW_WRITE = 1, RW_READ = 0.
  - The FSM state enum: IDLE, HDR, DATA, DONE.
- One natural sub-module: sig_sync_edge, an N-stage synchronizer with rise/fall pulse outputs, instantiated for sclk and sload; sdata uses a plain synchronizer.
- The sender and this responder share the package so frame layout stays consistent.

Test Plan:
- Write frame rw=1, addr=5, data=9'h1A5, sclk = clk/20 -> wr_stb pulses once, wr_addr=5, regs[53:45]=9'h1A5, all other regs unchanged.
- Read back after the write: rw=0, addr=5 -> sdata_oe rises after the 7th sclk rise; sampled bits 7..15 = 1,1,0,1,0,0,1,0,1; sdata_oe = 0 after sload high.
- Aborted write: sload raised after 10 bits, addr=2 -> frame_err pulses once, regs[26:18] keep their REG_RESET value, no wr_stb.
- Overrun: 17 sclk rises with rw=1, addr=0 -> frame_err, reg0 unchanged.
- Reset mid-read: rst_n low at bit 11 -> sdata_oe = 0 asynchronously, regs = REG_RESET; the next full write frame to addr 7 with data 9'h0FF commits normally.
- Back-to-back frames: write addr=1 data=9'h003, then after 1 sclk period of sload high, read addr=1 -> readback of 9'h003, exactly one wr_stb.
